serial_addsub_ctrl: RTL and testbench
=====================================

# serial_addsub_ctrl

- Multi-precision add/subtract sequencer built around one shared 4-bit nibble adder-subtractor.
- Accepts a wide operand pair and an add/sub opcode over a valid/ready handshake.
- Feeds the operands through the nibble datapath one nibble per cycle, LSB first, chaining the carry through a register.
- Returns the full-width result with the final carry; sits between the ALU issue logic and the result bus.

## Interface
- NIBBLES, default 4: operand width in nibbles; width W = 4*NIBBLES; legal range 2..16.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- in_op  input  1  0 = add (A+B), 1 = subtract (A-B).
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  W  A+B or A-B, modulo 2^W.
- out_carry  output  1  carry out of the MSB nibble; for subtract, 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow; present only with ADDSUB_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b and in_op; clear nibble index idx to 0; load the carry register with in_op; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, present A[idx], B[idx] and the carry register to the nibble unit, with invert-B = latched op.
  - Write the nibble sum into result[idx]; load the carry register with the nibble carry.
  - When idx = NIBBLES-1, go to DONE; otherwise idx+1.
- DONE:
  - out_valid=1; out_result and out_carry hold stable.
  - On out_ready, go to IDLE.
  - With out_ready low, hold indefinitely.
- Subtract is A + ~B + 1: invert-B on every nibble; the +1 is the initial carry only.
- in_valid outside IDLE is ignored; the requester holds it until in_ready.
- All arithmetic wraps modulo 2^W; no saturation.
- Reset at any time, including mid-RUN, aborts the operation; no partial result is emitted.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_carry=0, out_ovf=0, idx=0, carry register=0.

## Timing
- Request accepted on the edge where in_valid and in_ready are both 1 (cycle 0).
- RUN occupies cycles 1..NIBBLES.
- out_valid rises after the NIBBLES-th RUN edge; latency from acceptance is NIBBLES+1 edges.
- Result handshake on the edge where out_valid and out_ready are both 1; in_ready returns 1 in the next cycle.
- Minimum issue interval is NIBBLES+2 cycles.
- The nibble unit is combinational; all controller outputs are registered.

## Configuration
- ADDSUB_OVF_EN defined:
  - out_ovf is present.
  - It is registered in the final RUN cycle as carry-into-MSB XOR carry-out-of-MSB.
  - It is valid with out_valid.
- ADDSUB_OVF_EN undefined: out_ovf and its logic are absent; all other behaviour is identical.

## Structure
- Shared package addsub_pkg holds:
  - state enum ctrl_state_t {IDLE, RUN, DONE};
  - op constants OP_ADD=1'b0, OP_SUB=1'b1;
  - NIBBLE_W=4.
- One sub-module, nibble_addsub.
  - Purely combinational 4-bit adder with separate inputs: invert_b, carry_in.
  - Outputs: sum, carry_out, and msb_carry_in for overflow.
  - The controller instantiates it exactly once.

## Test plan
All scenarios use NIBBLES=4.
- Add 0x1234 + 0x0FFF -> out_result=0x2233, out_carry=0; out_valid exactly 5 edges after acceptance.
- Add 0xFFFF + 0x0001 -> out_result=0x0000, out_carry=1; carry ripples through all four nibbles.
- Subtract 0x0005 - 0x0007 -> out_result=0xFFFE, out_carry=0 (borrow); subtract 0x0007 - 0x0005 -> 0x0002, out_carry=1.
- With ADDSUB_OVF_EN: subtract 0x8000 - 0x0001 -> 0x7FFF, out_ovf=1; add 0x7FFF + 0x0001 -> 0x8000, out_ovf=1; add 0x0001 + 0x0001 -> out_ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> result stable, in_ready=0, second request not taken; raise out_ready -> second request accepted one cycle later.
- Assert rst_n low during the 2nd RUN cycle -> out_valid=0 and in_ready=1 immediately; a following request 0x0001 + 0x0001 -> 0x0002, unaffected by the aborted state.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial add/subtract sequencer.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/result handshake bundle for serial_addsub_ctrl.
// out_ovf exists only when ADDSUB_OVF_EN is defined.
interface serial_addsub_ctrl_if
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic         in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
`ifdef ADDSUB_OVF_EN
  logic         out_ovf;
`endif

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
`ifdef ADDSUB_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_result, out_carry
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
`ifdef ADDSUB_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_result, out_carry
  );

endinterface

// File: rtl/nibble_addsub.sv
// Combinational 4-bit adder/subtractor slice; also exposes the carry into
// bit 3 so the controller can derive signed overflow.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                invert_b_i,
  input  logic                carry_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                carry_o,
  output logic                msb_carry_o
);

  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W-1:0] low_sum;
  logic [1:0]          msb_sum;

  assign b_eff   = invert_b_i ? ~b_i : b_i;
  assign low_sum = {1'b0, a_i[NIBBLE_W-2:0]} + {1'b0, b_eff[NIBBLE_W-2:0]}
                   + {{(NIBBLE_W-1){1'b0}}, carry_i};
  assign msb_sum = {1'b0, a_i[NIBBLE_W-1]} + {1'b0, b_eff[NIBBLE_W-1]}
                   + {1'b0, low_sum[NIBBLE_W-1]};

  assign sum_o       = {msb_sum[0], low_sum[NIBBLE_W-2:0]};
  assign carry_o     = msb_sum[1];
  assign msb_carry_o = low_sum[NIBBLE_W-1];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Multi-precision add/subtract sequencer: one nibble per cycle, LSB first.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output out_ovf.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  serial_addsub_ctrl_if.slave   bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  ctrl_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout, nib_msb_c;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  nibble_addsub u_nibble (
    .a_i         (nib_a),
    .b_i         (nib_b),
    .invert_b_i  (op_q),
    .carry_i     (carry_q),
    .sum_o       (nib_sum),
    .carry_o     (nib_cout),
    .msb_carry_o (nib_msb_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          op_d    = bus.in_op;
          idx_d   = '0;
          // Subtract's +1 enters here, as the initial carry only
          carry_d = bus.in_op;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        if (idx_q == IDX_LAST) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_carry  = carry_q;

`ifdef ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && idx_q == IDX_LAST) ovf_d = nib_msb_c ^ nib_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.out_ovf = ovf_q;
`else
  logic unused_msb_c;
  assign unused_msb_c = nib_msb_c;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed-vector bench for serial_addsub_ctrl (NIBBLES=4).
module tb_serial_addsub_ctrl;
  import addsub_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl_if #(.NIBBLES(NIB)) bus ();

  serial_addsub_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid; returns edge count including the acceptance edge.
  task automatic wait_result(output int edges);
    edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    check("ready_before_issue", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r,
                        input logic exp_c, input logic exp_o);
    int edges;
    issue(op, a, b);
    wait_result(edges);
    check({tag, "_latency"}, 32'(edges), 32'(NIB + 1));
    check({tag, "_result"},  32'(bus.out_result), 32'(exp_r));
    check({tag, "_carry"},   32'(bus.out_carry), 32'(exp_c));
`ifdef ADDSUB_OVF_EN
    check({tag, "_ovf"},     32'(bus.out_ovf), 32'(exp_o));
`else
    if (exp_o === 1'bx) check({tag, "_ovf_arg"}, 32'(exp_o), 32'd0);
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int edges;
    logic [W-1:0] held;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.out_result), 32'd0);
    check("rst_carry",     32'(bus.out_carry), 32'd0);
`ifdef ADDSUB_OVF_EN
    check("rst_ovf",       32'(bus.out_ovf), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    run_op("add_1234_0fff", OP_ADD, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    run_op("add_ffff_0001", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("sub_5_7",       OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_7_5",       OP_SUB, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    run_op("sub_8000_1",    OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_7fff_1",    OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("add_1_1",       OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    // Backpressure: hold DONE with a second request pending.
    issue(OP_ADD, 16'h00FF, 16'h0001);
    wait_result(edges);
    check("bp_first_latency", 32'(edges), 32'(NIB + 1));
    check("bp_first_result",  32'(bus.out_result), 32'h0100);
    held = bus.out_result;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_SUB;
    bus.in_a     = 16'h0010;
    bus.in_b     = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", 32'(bus.out_result), 32'(held));
      check("bp_hold_ready",  32'(bus.in_ready), 32'd0);
      check("bp_hold_valid",  32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_second_taken", 32'(bus.in_ready), 32'd0);
    wait_result(edges);
    check("bp_second_latency", 32'(edges), 32'(NIB + 1));
    check("bp_second_result",  32'(bus.out_result), 32'h000F);
    check("bp_second_carry",   32'(bus.out_carry), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset during the second RUN cycle aborts the operation.
    issue(OP_ADD, 16'hFFFF, 16'hFFFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus.in_ready), 32'd1);
    check("abort_result",    32'(bus.out_result), 32'd0);
    check("abort_carry",     32'(bus.out_carry), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_stays_idle", 32'(bus.out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_abort_1_1", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
